memory_copy_engine: RTL
=======================

// Module: memory_copy_engine
// PURPOSE
//  Bus initiator for the single-port word memory. Copies a block of LENGTH words from
//  source to destination address, one word per READ/WRITE cycle pair. Sits between
//  control logic (start/done handshake) and the memory's address/data/write-enable
//  ports. Reports out-of-range accesses via the memory's registered invalid-address flag.
// PARAMETERS
//  WORD_SIZE     32  data and address width; matches memory WORD_SIZE
//  LENGTH_WIDTH  16  width of block length and word counter
// PORTS
//  clock                  in   1             single clock, all state on posedge
//  reset_n                in   1             asynchronous, active-low reset
//  start                  in   1             request copy; sampled only while busy=0
//  src_address            in   WORD_SIZE     first source word address, latched on start
//  dst_address            in   WORD_SIZE     first destination word address, latched on start
//  length                 in   LENGTH_WIDTH  words to copy, latched on start; 0 is legal
//  busy                   out  1             high from the cycle after start until done
//  done                   out  1             one-cycle completion pulse (success or abort)
//  words_copied           out  LENGTH_WIDTH  count of committed writes; held until next start
//  err_read_address       out  1             sticky: abort caused by invalid source address
//  err_write_address      out  1             sticky: abort caused by invalid destination address
//  mem_write_enabled      out  1             memory write strobe
//  mem_address            out  WORD_SIZE     memory address
//  mem_write_data         out  WORD_SIZE     memory write data
//  mem_read_data          in   WORD_SIZE     memory read data; combinational from mem_address
//  mem_err_invalid_address in  1             memory error flag; registered, so it reflects
//                                            the address presented in the previous cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE. busy, done, err_*, mem_write_enabled = 0.
//   words_copied, mem_address, mem_write_data = 0. Mid-copy reset abandons the copy at once.
//   No done pulse is issued.
//  States: IDLE, READ, WRITE, FLUSH.
//  IDLE: mem_write_enabled=0. When start=1 at a posedge: latch src, dst and length;
//   clear err_* and words_copied; index i=0. If length=0, go to FLUSH. Otherwise go to READ.
//  READ: mem_address=src+i, mem_write_enabled=0. Capture mem_read_data into data_reg at posedge.
//   If i>0 and mem_err_invalid_address=1 (previous dst write invalid): set err_write_address,
//   go to IDLE, pulse done. Otherwise go to WRITE.
//  WRITE: mem_address=dst+i, mem_write_data=data_reg,
//   mem_write_enabled = ~mem_err_invalid_address.
//   If the flag is 1 (src invalid): no write, set err_read_address, go to IDLE, pulse done.
//   Otherwise words_copied++ and i++. Go to FLUSH if i==length-1, else go to READ.
//  FLUSH: mem_write_enabled=0, mem_address held. If length>0 and mem_err_invalid_address=1,
//   set err_write_address. Go to IDLE and pulse done.
//  A write to an invalid destination has already been issued when the error is detected.
//   It is still counted in words_copied and is flagged, not undone.
//  done: registered and high for exactly the first IDLE cycle after FLUSH or an abort.
//   busy is low in that cycle.
//  Timing: start at edge 0 with length L>0 -> done high in the cycle following edge 2L+1.
//   L=0 -> done following edge 1, with no memory access.
//  start while busy=1 is ignored and is not queued. start in the done cycle is accepted.
//  Address arithmetic is modulo 2^WORD_SIZE. Wrap past memory end is reported by the memory.
//  Copy order is ascending, so overlapping regions with dst>src propagate the first words.
// STRUCTURE
//  Shared package: state encodings (IDLE/READ/WRITE/FLUSH), ON/OFF constants.
//  No sub-module. The FSM, index counter and data_reg live in one module.
// TESTING
//  src=0,dst=100,len=4, mem[0..3]=A,B,C,D -> mem[100..103]=A..D; done after edge 9;
//   words_copied=4; no err_*.
//  len=0 -> done after edge 1; mem_write_enabled never high; words_copied=0.
//  src=1022,dst=0,len=4 (MEMORY_SIZE=1024) -> mem[0..1] written; third WRITE suppressed;
//   err_read_address=1; words_copied=2.
//  src=0,dst=1023,len=3 -> writes to 1023 and 1024 issued; err_write_address=1 in READ of word 2;
//   words_copied=2.
//  reset_n low for 1 cycle mid-copy at word 2 of len=8 -> outputs 0 immediately; no done;
//   a new start then runs normally.
//  start pulsed again while busy -> ignored. start in the done cycle -> second copy begins.

Source files
------------

// File: rtl/memory_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and
// single-bit ON/OFF constants.
package memory_copy_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

endpackage

// File: rtl/memory_copy_engine.sv
// Block copy initiator for a single-port word memory: one READ/WRITE cycle pair
// per word, aborting on the memory's registered invalid-address flag.
module memory_copy_engine
   import memory_copy_engine_pkg::*;
#(
   parameter int WORD_SIZE    = 32,
   parameter int LENGTH_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [WORD_SIZE-1:0]    src_address,
   input  logic [WORD_SIZE-1:0]    dst_address,
   input  logic [LENGTH_WIDTH-1:0] length,
   output logic                    busy,
   output logic                    done,
   output logic [LENGTH_WIDTH-1:0] words_copied,
   output logic                    err_read_address,
   output logic                    err_write_address,
   output logic                    mem_write_enabled,
   output logic [WORD_SIZE-1:0]    mem_address,
   output logic [WORD_SIZE-1:0]    mem_write_data,
   input  logic [WORD_SIZE-1:0]    mem_read_data,
   input  logic                    mem_err_invalid_address
);

   state_t                  r_state, w_state_nx;
   logic [WORD_SIZE-1:0]    r_src, w_src_nx;
   logic [WORD_SIZE-1:0]    r_dst, w_dst_nx;
   logic [WORD_SIZE-1:0]    r_addr, w_addr_nx;
   logic [WORD_SIZE-1:0]    r_data, w_data_nx;
   logic [LENGTH_WIDTH-1:0] r_len, w_len_nx;
   logic [LENGTH_WIDTH-1:0] r_idx, w_idx_nx;
   logic [LENGTH_WIDTH-1:0] r_count, w_count_nx;
   logic                    r_busy, w_busy_nx;
   logic                    r_done, w_done_nx;
   logic                    r_err_rd, w_err_rd_nx;
   logic                    r_err_wr, w_err_wr_nx;
   logic                    r_we_arm, w_we_arm_nx;
   logic [LENGTH_WIDTH-1:0] w_idx_inc;
   logic                    w_last;

   assign w_idx_inc = r_idx + LENGTH_WIDTH'(1);
   assign w_last    = (r_idx == (r_len - LENGTH_WIDTH'(1)));

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state, address sequencing and status updates
   always_comb begin
      w_state_nx  = r_state;
      w_src_nx    = r_src;
      w_dst_nx    = r_dst;
      w_len_nx    = r_len;
      w_idx_nx    = r_idx;
      w_addr_nx   = r_addr;
      w_data_nx   = r_data;
      w_count_nx  = r_count;
      w_err_rd_nx = r_err_rd;
      w_err_wr_nx = r_err_wr;
      w_done_nx   = OFF;
      w_we_arm_nx = OFF;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_src_nx    = src_address;
               w_dst_nx    = dst_address;
               w_len_nx    = length;
               w_idx_nx    = '0;
               w_count_nx  = '0;
               w_err_rd_nx = OFF;
               w_err_wr_nx = OFF;
               if (length == '0) begin
                  w_state_nx = ST_FLUSH;
               end else begin
                  w_state_nx = ST_READ;
                  w_addr_nx  = src_address;
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_READ: begin
            w_data_nx = mem_read_data;
            // Flag here belongs to the previous word's destination write
            if ((r_idx != '0) && mem_err_invalid_address) begin
               w_err_wr_nx = ON;
               w_done_nx   = ON;
               w_state_nx  = ST_IDLE;
            end else begin
               w_state_nx  = ST_WRITE;
               w_addr_nx   = r_dst + WORD_SIZE'(r_idx);
               w_we_arm_nx = ON;
            end
         end
         ST_WRITE: begin
            if (mem_err_invalid_address) begin
               w_err_rd_nx = ON;
               w_done_nx   = ON;
               w_state_nx  = ST_IDLE;
            end else begin
               w_count_nx = r_count + LENGTH_WIDTH'(1);
               w_idx_nx   = w_idx_inc;
               if (w_last) begin
                  w_state_nx = ST_FLUSH;
               end else begin
                  w_state_nx = ST_READ;
                  w_addr_nx  = r_src + WORD_SIZE'(w_idx_inc);
               end
            end
         end
         ST_FLUSH: begin
            if ((r_len != '0) && mem_err_invalid_address) begin
               w_err_wr_nx = ON;
            end else begin
               w_err_wr_nx = r_err_wr;
            end
            w_done_nx  = ON;
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
      w_busy_nx = (w_state_nx != ST_IDLE);
   end

   // Datapath and status registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_len    <= '0;
         r_idx    <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_count  <= '0;
         r_busy   <= OFF;
         r_done   <= OFF;
         r_err_rd <= OFF;
         r_err_wr <= OFF;
         r_we_arm <= OFF;
      end else begin
         r_src    <= w_src_nx;
         r_dst    <= w_dst_nx;
         r_len    <= w_len_nx;
         r_idx    <= w_idx_nx;
         r_addr   <= w_addr_nx;
         r_data   <= w_data_nx;
         r_count  <= w_count_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         r_err_rd <= w_err_rd_nx;
         r_err_wr <= w_err_wr_nx;
         r_we_arm <= w_we_arm_nx;
      end
   end

   // The memory flag for the source read arrives during WRITE, so the strobe is gated live
   assign mem_write_enabled = r_we_arm & ~mem_err_invalid_address;
   assign mem_address       = r_addr;
   assign mem_write_data    = r_data;
   assign busy              = r_busy;
   assign done              = r_done;
   assign words_copied      = r_count;
   assign err_read_address  = r_err_rd;
   assign err_write_address = r_err_wr;

endmodule
